// File: rtl/otter_mem_port_arbiter_if.sv
// Shared bus bundle between pipeline requesters, arbiter and memory.
// master = arbiter side, slave = requesters/memory side.
interface otter_mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_RVALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              D_REQ;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic [1:0]        D_SIZE;
    logic              D_SIGN;
    logic              D_GNT;
    logic              D_RVALID;
    logic [DATA_W-1:0] D_RDATA;

    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic [1:0]        M_SIZE;
    logic              M_SIGN;
    logic              M_GNT;
    logic              M_RVALID;
    logic [DATA_W-1:0] M_RDATA;

    logic              BUSY;
    logic              OWNER;
    logic              SPURIOUS;

    modport master (
        input  IF_REQ, IF_ADDR,
        output IF_GNT, IF_RVALID, IF_RDATA,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        output D_GNT, D_RVALID, D_RDATA,
        output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
        input  M_GNT, M_RVALID, M_RDATA,
        output BUSY, OWNER, SPURIOUS
    );

    modport slave (
        output IF_REQ, IF_ADDR,
        input  IF_GNT, IF_RVALID, IF_RDATA,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        input  D_GNT, D_RVALID, D_RDATA,
        input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
        output M_GNT, M_RVALID, M_RDATA,
        input  BUSY, OWNER, SPURIOUS
    );
endinterface

// File: rtl/otter_mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory bus.
// One outstanding transaction; data priority with a fetch-starvation bound.
module otter_mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic CLK,
    input logic RST_N,
    otter_mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              owner_q, owner_d;
    logic              spurious_q, spurious_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              d_win;

    // Data wins unless fetch is waiting and the data streak is exhausted.
    assign d_win = bus.D_REQ && !(bus.IF_REQ && streak_q == STREAK_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            owner_q    <= 1'b0;
            spurious_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            owner_q    <= owner_d;
            spurious_q <= spurious_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        owner_d       = owner_q;
        spurious_d    = spurious_q | (bus.M_RVALID && state_q != RESP);
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        sign_d        = sign_q;
        bus.IF_GNT    = 1'b0;
        bus.D_GNT     = 1'b0;
        bus.IF_RVALID = 1'b0;
        bus.D_RVALID  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_win) begin
                    bus.D_GNT = 1'b1;
                    owner_d   = 1'b1;
                    we_d      = bus.D_WE;
                    addr_d    = bus.D_ADDR;
                    wdata_d   = bus.D_WDATA;
                    size_d    = bus.D_SIZE;
                    sign_d    = bus.D_SIGN;
                    state_d   = REQ;
                    if (!bus.IF_REQ)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (bus.IF_REQ) begin
                    bus.IF_GNT = 1'b1;
                    owner_d    = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = bus.IF_ADDR;
                    wdata_d    = '0;
                    size_d     = 2'd2;
                    sign_d     = 1'b0;
                    streak_d   = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.M_GNT)
                    state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                if (bus.M_RVALID) begin
                    state_d = IDLE;
                    if (owner_q)
                        bus.D_RVALID = 1'b1;
                    else
                        bus.IF_RVALID = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.M_REQ     = (state_q == REQ);
    assign bus.M_WE      = we_q;
    assign bus.M_ADDR    = addr_q;
    assign bus.M_WDATA   = wdata_q;
    assign bus.M_SIZE    = size_q;
    assign bus.M_SIGN    = sign_q;
    assign bus.IF_RDATA  = bus.M_RDATA;
    assign bus.D_RDATA   = bus.M_RDATA;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OWNER     = owner_q;
    assign bus.SPURIOUS  = spurious_q;
endmodule

// File: tb/tb_otter_mem_port_arbiter.sv
// Scoreboard bench for otter_mem_port_arbiter.
// Read data expected per port is queued at grant and popped on RVALID.
module tb_otter_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int n_chk;
  int n_fail;

  otter_mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  otter_mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  byte gnt_log[$];

  bit mem_auto;
  int gnt_delay;
  int wait_cnt;
  bit rv_pending;
  logic [31:0] rv_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: grants after gnt_delay cycles of M_REQ, read data next cycle.
  initial begin
    wait_cnt = 0;
    rv_pending = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rv_pending = 1'b0;
        wait_cnt = 0;
      end else if (mem_auto) begin
        bus.M_GNT = 1'b0;
        bus.M_RVALID = rv_pending;
        if (rv_pending) bus.M_RDATA = mem_fn(rv_addr);
        rv_pending = 1'b0;
        if (bus.M_REQ) begin
          if (wait_cnt >= gnt_delay) begin
            bus.M_GNT = 1'b1;
            wait_cnt = 0;
            if (!bus.M_WE) begin
              rv_pending = 1'b1;
              rv_addr = bus.M_ADDR;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Monitor/scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.IF_GNT && bus.D_GNT)
          chk("dual_gnt", 1, 0);
        if (bus.IF_GNT) begin
          exp_if.push_back(mem_fn(bus.IF_ADDR));
          gnt_log.push_back("F");
        end
        if (bus.D_GNT) begin
          if (!bus.D_WE) exp_d.push_back(mem_fn(bus.D_ADDR));
          gnt_log.push_back("D");
        end
        if (bus.IF_RVALID) begin
          if (exp_if.size() == 0) chk("if_rvalid_unexp", 1, 0);
          else chk("if_rdata", bus.IF_RDATA, exp_if.pop_front());
        end
        if (bus.D_RVALID) begin
          if (exp_d.size() == 0) chk("d_rvalid_unexp", 1, 0);
          else chk("d_rdata", bus.D_RDATA, exp_d.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (bus.BUSY && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    string order;
    n_chk = 0;
    n_fail = 0;
    mem_auto = 1'b1;
    gnt_delay = 0;
    rst_n = 1'b0;
    bus.IF_REQ = 0; bus.IF_ADDR = '0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = '0;
    bus.D_WDATA = '0; bus.D_SIZE = '0; bus.D_SIGN = 0;
    bus.M_GNT = 0; bus.M_RVALID = 0; bus.M_RDATA = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_mreq", bus.M_REQ, 0);
    chk("rst_owner", bus.OWNER, 0);
    chk("rst_spur", bus.SPURIOUS, 0);
    chk("rst_mwe", bus.M_WE, 0);
    chk("rst_maddr", bus.M_ADDR, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single fetch, minimum latency
    @(posedge clk); #1;
    bus.IF_REQ = 1; bus.IF_ADDR = 32'h100;
    @(negedge clk);
    chk("f_ifgnt", bus.IF_GNT, 1);
    chk("f_dgnt", bus.D_GNT, 0);
    @(posedge clk); #1 bus.IF_REQ = 0;
    @(negedge clk);
    chk("f_mreq", bus.M_REQ, 1);
    chk("f_maddr", bus.M_ADDR, 32'h100);
    chk("f_mwe", bus.M_WE, 0);
    chk("f_msize", bus.M_SIZE, 2);
    @(negedge clk);
    chk("f_rvalid", bus.IF_RVALID, 1);
    chk("f_rdata", bus.IF_RDATA, 32'h0050_0093);
    @(negedge clk);
    chk("f_busy", bus.BUSY, 0);

    // Conflict: data first, fetch after the data response
    @(posedge clk); #1;
    bus.IF_REQ = 1; bus.IF_ADDR = 32'h104;
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 32'h2000; bus.D_SIZE = 2;
    @(negedge clk);
    chk("c_dgnt", bus.D_GNT, 1);
    chk("c_ifgnt0", bus.IF_GNT, 0);
    @(posedge clk); #1 bus.D_REQ = 0;
    @(negedge clk);
    chk("c_owner", bus.OWNER, 1);
    chk("c_maddr", bus.M_ADDR, 32'h2000);
    @(negedge clk);
    chk("c_drvalid", bus.D_RVALID, 1);
    chk("c_ifrvalid", bus.IF_RVALID, 0);
    chk("c_ifgnt1", bus.IF_GNT, 0);
    @(negedge clk);
    chk("c_ifgnt2", bus.IF_GNT, 1);
    @(posedge clk); #1 bus.IF_REQ = 0;
    wait_idle();

    // Starvation bound
    @(posedge clk); #1;
    gnt_log.delete();
    bus.IF_REQ = 1; bus.IF_ADDR = 32'h300;
    bus.D_REQ = 1; bus.D_WE = 0; bus.D_ADDR = 32'h4000;
    for (int c = 0; c < 200 && gnt_log.size() < 10; c++)
      @(negedge clk);
    @(posedge clk); #1;
    bus.IF_REQ = 0; bus.D_REQ = 0;
    if (gnt_log.size() < 10) chk("s_timeout", gnt_log.size(), 10);
    order = "DDDDFDDDDF";
    for (int i = 0; i < 10; i++)
      chk($sformatf("s_order%0d", i), gnt_log[i], order[i]);
    wait_idle();

    // Write with delayed memory grant
    gnt_delay = 3;
    @(posedge clk); #1;
    bus.D_REQ = 1; bus.D_WE = 1; bus.D_ADDR = 32'h1100_0040;
    bus.D_WDATA = 32'hDEAD_BEEF; bus.D_SIZE = 0;
    @(negedge clk);
    chk("w_dgnt", bus.D_GNT, 1);
    @(posedge clk); #1;
    bus.D_REQ = 0; bus.D_ADDR = 32'h5555_5555;
    bus.D_WDATA = 32'h1234_5678; bus.D_SIZE = 2; bus.D_WE = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w_mreq", bus.M_REQ, 1);
      chk("w_mgnt0", bus.M_GNT, 0);
      chk("w_mwe", bus.M_WE, 1);
      chk("w_maddr", bus.M_ADDR, 32'h1100_0040);
      chk("w_mwdata", bus.M_WDATA, 32'hDEAD_BEEF);
      chk("w_msize", bus.M_SIZE, 0);
    end
    @(negedge clk);
    chk("w_mgnt", bus.M_GNT, 1);
    chk("w_mreq_last", bus.M_REQ, 1);
    @(negedge clk);
    chk("w_idle", bus.BUSY, 0);
    chk("w_nodrv", bus.D_RVALID, 0);
    gnt_delay = 0;

    // Reset during RESP, then stray M_RVALID
    @(posedge clk); #1;
    mem_auto = 1'b0;
    bus.M_GNT = 0; bus.M_RVALID = 0;
    bus.IF_REQ = 1; bus.IF_ADDR = 32'h200;
    @(negedge clk);
    chk("r_ifgnt", bus.IF_GNT, 1);
    @(posedge clk); #1;
    bus.IF_REQ = 0; bus.M_GNT = 1;
    @(posedge clk); #1 bus.M_GNT = 0;
    @(negedge clk);
    chk("r_busy_resp", bus.BUSY, 1);
    chk("r_mreq_resp", bus.M_REQ, 0);
    #2 rst_n = 1'b0;
    exp_if.delete();
    exp_d.delete();
    #1;
    chk("r_busy0", bus.BUSY, 0);
    chk("r_owner0", bus.OWNER, 0);
    chk("r_mreq0", bus.M_REQ, 0);
    chk("r_maddr0", bus.M_ADDR, 0);
    chk("r_ifrv0", bus.IF_RVALID, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.M_RVALID = 1; bus.M_RDATA = 32'hCAFE_F00D;
    @(negedge clk);
    chk("r_ifrv", bus.IF_RVALID, 0);
    chk("r_drv", bus.D_RVALID, 0);
    @(posedge clk); #1 bus.M_RVALID = 0;
    @(negedge clk);
    chk("r_spur", bus.SPURIOUS, 1);
    chk("r_busy", bus.BUSY, 0);
    repeat (3) @(negedge clk);
    chk("r_spur_sticky", bus.SPURIOUS, 1);

    chk("q_if_empty", exp_if.size(), 0);
    chk("q_d_empty", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/otter_mem_port_arbiter.md
Name: otter_mem_port_arbiter

Overview:
- Shares one single-ported memory/IO bus between the instruction-fetch requester (port 0) and the MEM-stage data requester (port 1).
- Sequences each access with a request/grant/response handshake and allows one outstanding transaction at a time.
- Data has priority. A streak counter guarantees fetch progress.
- Sits between the pipeline stages and the memory. The pipeline derives its fetch and memory stalls from the grant and response outputs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting. Legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IF_REQ  in  1  fetch request; held until IF_GNT.
- IF_ADDR  in  ADDR_W  fetch address.
- IF_GNT  out  1  one-cycle pulse; fetch request accepted and latched.
- IF_RVALID  out  1  one-cycle pulse; IF_RDATA valid.
- IF_RDATA  out  DATA_W  fetch read data.
- D_REQ  in  1  data request; held until D_GNT.
- D_WE  in  1  1 = write, 0 = read.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  write data.
- D_SIZE  in  2  access size (0 = byte, 1 = half, 2 = word).
- D_SIGN  in  1  1 = unsigned load.
- D_GNT  out  1  one-cycle pulse; data request accepted and latched.
- D_RVALID  out  1  one-cycle pulse; D_RDATA valid. Asserted for reads only.
- D_RDATA  out  DATA_W  data read data.
- M_REQ  out  1  memory request; held until M_GNT.
- M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN  out  1/ADDR_W/DATA_W/2/1  latched request fields. Fetch forces M_WE=0, M_SIZE=2, M_SIGN=0.
- M_GNT  in  1  memory accepted the request.
- M_RVALID  in  1  read data valid. Arrives at least 1 cycle after M_GNT.
- M_RDATA  in  DATA_W  memory read data.
- BUSY  out  1  state is not IDLE.
- OWNER  out  1  0 = fetch, 1 = data; owner of the current transaction.
- SPURIOUS  out  1  sticky; M_RVALID was seen outside RESP.

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (async, RST_N=0):
  - state=IDLE, streak=0, OWNER=0, SPURIOUS=0.
  - M_REQ=0, M_WE=0, and all grant and valid outputs 0.
  - Latched fields cleared to 0.
  - Reset mid-transaction abandons the transaction. Any later M_RVALID counts as spurious.
- IDLE, arbitration:
  - If D_REQ and !(IF_REQ && streak==MAX_DATA_STREAK): grant data.
  - Else if IF_REQ: grant fetch.
  - GNT is combinational in the selection cycle. Request fields are latched at that edge and OWNER updates. Next state is REQ.
  - No request: remain in IDLE.
- Streak counter:
  - Data grant with IF_REQ=1: streak += 1, saturating at MAX_DATA_STREAK.
  - Data grant with IF_REQ=0: streak=0.
  - Fetch grant: streak=0.
- REQ:
  - M_REQ=1 with latched fields stable.
  - On M_GNT, a read goes to RESP.
  - On M_GNT, a write goes to IDLE; no response is generated.
- RESP:
  - M_REQ=0.
  - On M_RVALID, route M_RDATA combinationally to the owner's RDATA and pulse the owner's RVALID. Next state is IDLE.
  - The non-owner's RVALID stays 0. RDATA outputs are don't-care while RVALID=0.
- Back-to-back traffic: no new grant in the cycle RESP is exited.
  - Minimum read occupancy: grant (cycle 0), M_REQ (cycle 1, M_GNT same cycle), M_RVALID (cycle 2), next grant (cycle 3).
  - Minimum write occupancy: 2 cycles.
- Simultaneous IF_REQ and D_REQ: data wins unless the streak has saturated.
- Requester behaviour: requests are not revocable before GNT. A requester may change its fields or drop its request in the cycle after GNT.
- SPURIOUS: M_RVALID in IDLE or REQ sets SPURIOUS, which is cleared only by reset. The data is discarded and no RVALID is pulsed.

Test Plan:
- Single fetch: IF_REQ, IF_ADDR=0x100; M_GNT at cycle 1; M_RVALID with M_RDATA=0x00500093 at cycle 2 -> IF_GNT at cycle 0, M_ADDR=0x100 with M_WE=0 and M_SIZE=2 at cycle 1, IF_RVALID=1 with IF_RDATA=0x00500093 at cycle 2, BUSY=0 at cycle 3.
- Conflict: IF_REQ and D_REQ (read, 0x2000) asserted together -> D_GNT first, OWNER=1, D_RVALID only. IF_GNT comes in the cycle after the data response.
- Starvation: IF_REQ and D_REQ held high with MAX_DATA_STREAK=4 and single-cycle memory -> grant order D,D,D,D,F,D,D,D,D,F.
- Write: D_WE=1, D_ADDR=0x11000040, D_WDATA=0xDEADBEEF, D_SIZE=0; M_GNT delayed 3 cycles -> M_REQ held with stable fields for 3 cycles, no D_RVALID, IDLE after M_GNT.
- Reset mid-operation: RST_N low while in RESP, then M_RVALID after release -> all outputs 0 immediately, no RVALID pulse, SPURIOUS=1.
